// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [1:0] CLS_NONE = 2'd0;
  localparam logic [1:0] CLS_JMP  = 2'd1;
  localparam logic [1:0] CLS_BR   = 2'd2;
  localparam logic [1:0] CLS_EXC  = 2'd3;

  // step must be a power of two; the low log2(step) bits must be zero
  function automatic logic is_aligned(input logic [63:0] addr, input int unsigned step);
    logic [63:0] mask;
    mask = 64'(step) - 64'd1;
    return (addr & mask) == '0;
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential successor: pc + STEP, wrapping modulo 2^ADDR_W.
module pc_incr #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STEP   = 4
) (
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] sum
);

  assign sum = pc + ADDR_W'(STEP);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: sequential advance, prioritised redirects,
// stall-time redirect buffering and misaligned-target trapping.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       STEP      = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0080)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              exc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redirect,
  output logic              misalign,
  output logic              pend_valid
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] pc_n;
  logic              redirect_n, misalign_n;
  logic              pend_valid_n;
  logic [ADDR_W-1:0] pend_tgt, pend_tgt_n;
  logic [1:0]        pend_cls, pend_cls_n;
  logic [1:0]        req_cls;
  logic [ADDR_W-1:0] req_tgt;
  logic              req_mis;

  pc_incr #(
    .ADDR_W (ADDR_W),
    .STEP   (STEP)
  ) u_incr (
    .pc  (pc),
    .sum (incr)
  );

  assign next_pc   = incr;
  assign out_valid = (state == RUN);

  // Misaligned branch/jump targets are promoted to exception class.
  always_comb begin
    req_cls = CLS_NONE;
    req_tgt = '0;
    req_mis = 1'b0;
    if (exc) begin
      req_cls = CLS_EXC;
      req_tgt = EXC_VEC;
    end else if (br_taken) begin
      if (is_aligned(64'(br_target), STEP)) begin
        req_cls = CLS_BR;
        req_tgt = br_target;
      end else begin
        req_cls = CLS_EXC;
        req_tgt = EXC_VEC;
        req_mis = 1'b1;
      end
    end else if (jmp) begin
      if (is_aligned(64'(jmp_target), STEP)) begin
        req_cls = CLS_JMP;
        req_tgt = jmp_target;
      end else begin
        req_cls = CLS_EXC;
        req_tgt = EXC_VEC;
        req_mis = 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    redirect_n   = 1'b0;
    misalign_n   = 1'b0;
    pend_valid_n = pend_valid;
    pend_tgt_n   = pend_tgt;
    pend_cls_n   = pend_cls;
    unique case (state)
      BOOT, RUN: begin
        if (state == BOOT || stall) begin
          // BOOT shares the stall path: hold pc, buffer the request
          state_n = RUN;
          if (req_cls != CLS_NONE && (!pend_valid || req_cls >= pend_cls)) begin
            pend_valid_n = 1'b1;
            pend_tgt_n   = req_tgt;
            pend_cls_n   = req_cls;
            misalign_n   = req_mis;
          end
        end else if (pend_valid && req_cls > pend_cls) begin
          pc_n         = req_tgt;
          redirect_n   = 1'b1;
          misalign_n   = req_mis;
          pend_valid_n = 1'b0;
        end else if (pend_valid) begin
          pc_n         = pend_tgt;
          redirect_n   = 1'b1;
          pend_valid_n = 1'b0;
        end else if (req_cls != CLS_NONE) begin
          pc_n       = req_tgt;
          redirect_n = 1'b1;
          misalign_n = req_mis;
        end else if (out_ready) begin
          pc_n = incr;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_VEC;
      redirect   <= 1'b0;
      misalign   <= 1'b0;
      pend_valid <= 1'b0;
      pend_tgt   <= '0;
      pend_cls   <= CLS_NONE;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      redirect   <= redirect_n;
      misalign   <= misalign_n;
      pend_valid <= pend_valid_n;
      pend_tgt   <= pend_tgt_n;
      pend_cls   <= pend_cls_n;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit: a 32-bit default instance driven from a
// table, plus an 8-bit instance for wrap-around and misalignment sequences.
module tb_pc_unit;

  logic        clk;
  logic        rst_n, stall, exc, br_taken, jmp, out_ready;
  logic [31:0] br_target, jmp_target;
  logic        out_valid, redirect, misalign, pend_valid;
  logic [31:0] pc, next_pc;

  logic       s_rst_n, s_stall, s_exc, s_br, s_jmp, s_rdy;
  logic [7:0] s_brt, s_jt;
  logic       s_ov, s_rd, s_mis, s_pv;
  logic [7:0] s_pc, s_npc;

  int unsigned checks = 0;
  int unsigned passed = 0;

  pc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .exc        (exc),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .pc         (pc),
    .next_pc    (next_pc),
    .redirect   (redirect),
    .misalign   (misalign),
    .pend_valid (pend_valid)
  );

  pc_unit #(
    .ADDR_W    (8),
    .STEP      (4),
    .RESET_VEC (8'h00),
    .EXC_VEC   (8'h80)
  ) dut8 (
    .clk        (clk),
    .rst_n      (s_rst_n),
    .stall      (s_stall),
    .exc        (s_exc),
    .br_taken   (s_br),
    .br_target  (s_brt),
    .jmp        (s_jmp),
    .jmp_target (s_jt),
    .out_ready  (s_rdy),
    .out_valid  (s_ov),
    .pc         (s_pc),
    .next_pc    (s_npc),
    .redirect   (s_rd),
    .misalign   (s_mis),
    .pend_valid (s_pv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, stall, exc, br, jmp, rdy;
    logic [31:0] brt, jt;
    logic [31:0] pc;
    logic        rd, mis, pv, ov;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic s, input logic e,
                     input logic b, input logic [31:0] bt,
                     input logic j, input logic [31:0] jt, input logic rdy,
                     input logic [31:0] epc, input logic erd, input logic emis,
                     input logic epv, input logic eov);
    vec_t v;
    v.rst_n = r; v.stall = s; v.exc = e; v.br = b; v.brt = bt;
    v.jmp = j; v.jt = jt; v.rdy = rdy;
    v.pc = epc; v.rd = erd; v.mis = emis; v.pv = epv; v.ov = eov;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; exc = 1'b0; br_taken = 1'b0; jmp = 1'b0;
    out_ready = 1'b0; br_target = '0; jmp_target = '0;
    s_rst_n = 1'b0; s_stall = 1'b0; s_exc = 1'b0; s_br = 1'b0; s_jmp = 1'b0;
    s_rdy = 1'b0; s_brt = '0; s_jt = '0;

    //  rst stl exc br  brt         jmp jt          rdy  pc          rd mis pv ov
    add(0, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h0,      0, 0, 0, 0);
    add(0, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h0,      0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h0,      0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h4,      0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h8,      0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      0,   32'h8,      0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      0,   32'h8,      0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      0,   32'h8,      0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'hC,      0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h10,     0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h14,     0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h18,     0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h1C,     0, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h20,     0, 0, 0, 1);
    // br beats jmp; then exc beats both
    add(1, 0, 0, 1, 32'h100,    1, 32'h200,    1,   32'h100,    1, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h104,    0, 0, 0, 1);
    add(1, 0, 1, 1, 32'h100,    1, 32'h200,    1,   32'h80,     1, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h84,     0, 0, 0, 1);
    // buffered redirect: jmp then br while stalled
    add(1, 0, 0, 0, 32'h0,      1, 32'h40,     0,   32'h40,     1, 0, 0, 1);
    add(1, 1, 0, 0, 32'h0,      1, 32'h300,    1,   32'h40,     0, 0, 1, 1);
    add(1, 1, 0, 1, 32'h400,    0, 32'h0,      1,   32'h40,     0, 0, 1, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h400,    1, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h404,    0, 0, 0, 1);
    // misaligned branch traps
    add(1, 0, 0, 1, 32'h102,    0, 32'h0,      1,   32'h80,     1, 1, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h84,     0, 0, 0, 1);
    // lower-class requests lose to a pending br
    add(1, 1, 0, 1, 32'h500,    0, 32'h0,      1,   32'h84,     0, 0, 1, 1);
    add(1, 1, 0, 0, 32'h0,      1, 32'h600,    1,   32'h84,     0, 0, 1, 1);
    add(1, 0, 0, 0, 32'h0,      1, 32'h700,    1,   32'h500,    1, 0, 0, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h504,    0, 0, 0, 1);
    // higher-class request at stall release beats pending jmp
    add(1, 1, 0, 0, 32'h0,      1, 32'h600,    1,   32'h504,    0, 0, 1, 1);
    add(1, 0, 0, 1, 32'h800,    0, 32'h0,      1,   32'h800,    1, 0, 0, 1);
    // misaligned jmp buffered during stall, applied without out_ready
    add(1, 1, 0, 0, 32'h0,      1, 32'h901,    1,   32'h800,    0, 1, 1, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      0,   32'h80,     1, 0, 0, 1);
    add(1, 1, 0, 0, 32'h0,      0, 32'h0,      1,   32'h80,     0, 0, 0, 1);
    // reset mid-stall with pending, then a request buffered during BOOT
    add(1, 1, 0, 1, 32'h1000,   0, 32'h0,      1,   32'h80,     0, 0, 1, 1);
    add(0, 1, 0, 0, 32'h0,      0, 32'h0,      1,   32'h0,      0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,      1, 32'h44,     1,   32'h0,      0, 0, 1, 1);
    add(1, 0, 0, 0, 32'h0,      0, 32'h0,      1,   32'h44,     1, 0, 0, 1);

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n; stall = vq[i].stall; exc = vq[i].exc;
      br_taken = vq[i].br; br_target = vq[i].brt;
      jmp = vq[i].jmp; jmp_target = vq[i].jt; out_ready = vq[i].rdy;
      tick();
      chk($sformatf("v%0d.pc", i),        pc,                  vq[i].pc);
      chk($sformatf("v%0d.next_pc", i),   next_pc,             vq[i].pc + 32'd4);
      chk($sformatf("v%0d.redirect", i),  32'(redirect),       32'(vq[i].rd));
      chk($sformatf("v%0d.misalign", i),  32'(misalign),       32'(vq[i].mis));
      chk($sformatf("v%0d.pend_valid", i), 32'(pend_valid),    32'(vq[i].pv));
      chk($sformatf("v%0d.out_valid", i), 32'(out_valid),      32'(vq[i].ov));
    end

    // 8-bit instance: wrap from 0xFC to 0x00, then a misaligned branch
    s_rst_n = 1'b1;
    tick();
    chk("w8.boot_pc", 32'(s_pc), 32'h00);
    chk("w8.boot_ov", 32'(s_ov), 32'h1);
    s_jmp = 1'b1; s_jt = 8'hFC;
    tick();
    chk("w8.jmp_pc", 32'(s_pc), 32'hFC);
    chk("w8.jmp_rd", 32'(s_rd), 32'h1);
    chk("w8.wrap_next_pc", 32'(s_npc), 32'h00);
    s_jmp = 1'b0; s_rdy = 1'b1;
    tick();
    chk("w8.wrap_pc", 32'(s_pc), 32'h00);
    chk("w8.wrap_rd", 32'(s_rd), 32'h0);
    s_br = 1'b1; s_brt = 8'h03;
    tick();
    chk("w8.mis_pc", 32'(s_pc), 32'h80);
    chk("w8.mis_flag", 32'(s_mis), 32'h1);
    chk("w8.mis_rd", 32'(s_rd), 32'h1);
    s_br = 1'b0;
    tick();
    chk("w8.after_pc", 32'(s_pc), 32'h84);
    chk("w8.after_mis", 32'(s_mis), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the fixed PC+4 adder in the fetch stage.
- Holds the PC register and handles sequential advance by STEP.
- Handles exception, branch and jump redirects in priority order, stalls, and an instruction-memory valid/ready handshake.
- Buffers a redirect that arrives during a stall; traps misaligned targets to the exception vector.

Parameters:
- ADDR_W, 32, PC/target width in bits.
- STEP, 4, sequential increment in bytes; must be a power of two, at least 1.
- RESET_VEC, 32'h0000_0000, PC value loaded at reset; ADDR_W bits.
- EXC_VEC, 32'h0000_0080, exception/trap target; ADDR_W bits, STEP-aligned.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  pipeline hold; PC must not change while high
- exc  in  1  exception request; target is EXC_VEC
- br_taken  in  1  branch redirect request
- br_target  in  ADDR_W  branch target
- jmp  in  1  jump redirect request
- jmp_target  in  ADDR_W  jump target
- out_ready  in  1  imem accepts the current pc
- out_valid  out  1  pc is a valid fetch address
- pc  out  ADDR_W  current fetch address (registered)
- next_pc  out  ADDR_W  pc+STEP, combinational; used as the link value
- redirect  out  1  one-cycle pulse: pc was loaded from a redirect this cycle, downstream flushes
- misalign  out  1  one-cycle pulse: a misaligned br/jmp target was trapped
- pend_valid  out  1  a buffered redirect is waiting

Behaviour:
- Reset (rst_n=0 at a clk edge; overrides everything, including mid-stall and pending):
  - pc=RESET_VEC, out_valid=0, redirect=0, misalign=0, pend_valid=0, state=BOOT.
- States:
  - BOOT: out_valid=0. Next edge → RUN, pc unchanged.
  - RUN: out_valid=1.
  - There is no other state. The pending buffer is a separate register: pend_valid, pend_tgt, pend_cls.
- Request class, highest first: EXC(3) > BR(2) > JMP(1) > none(0).
  - The winning incoming request is called `req`. Lower-class simultaneous requests are dropped.
- Misalignment:
  - A BR/JMP target with any of bits [log2(STEP)-1:0] nonzero becomes class EXC with target EXC_VEC.
  - misalign pulses on the cycle that request is applied or buffered.
  - With STEP=1 nothing is misaligned.
- Update rule at each edge in RUN, with stall=0. First match wins:
  1. pend_valid=1 and req class > pend_cls: pc=req target, redirect=1, pend cleared.
  2. pend_valid=1 otherwise: pc=pend_tgt, redirect=1, pend cleared; req is dropped.
  3. req present: pc=req target, redirect=1.
  4. out_ready=1: pc=pc+STEP, modulo 2^ADDR_W (wraps to 0, no flag).
  5. Otherwise pc holds.
- A redirect does not wait for out_ready: it abandons the unaccepted fetch.
- Stall=1 in RUN:
  - pc holds, redirect=0.
  - If req present and (pend_valid=0 or req class >= pend_cls): pend ← req, pend_valid=1.
  - Otherwise pend is unchanged.
- Requests arriving in BOOT are buffered by the same rule as stall.
- Latency:
  - Redirect appears on pc 1 cycle after the request when not stalled.
  - When stalled, it appears 1 cycle after stall falls.
- next_pc is always pc+STEP with the same wrap; this is valid in BOOT too.

Decomposition:
- Package pc_pkg:
  - state enum {BOOT, RUN}
  - class constants CLS_NONE=0, CLS_JMP=1, CLS_BR=2, CLS_EXC=3 (2 bits)
  - helper function is_aligned(addr, STEP)
- Sub-module pc_incr, parametrised by ADDR_W and STEP: combinational pc+STEP. This is the generalised successor of the old adder and is shared by next_pc and the sequential path.

Test Plan:
- Reset and sequential:
  - rst_n low 2 cycles then high, out_ready=1.
  - Expect out_valid=0 with pc=0 for 1 cycle after release, then pc=0, 4, 8, 12…
  - next_pc always pc+4.
- Backpressure:
  - out_ready=0 for 3 cycles at pc=8 → pc holds 8.
  - Then ready=1 → pc=12.
- Simultaneous redirect:
  - At pc=0x20, br_taken=1 with br_target=0x100 and jmp=1 with jmp_target=0x200 → next pc=0x100, redirect pulses once.
  - Repeating with exc=1 also asserted → pc=0x80.
- Buffered redirect:
  - stall=1 at pc=0x40; jmp to 0x300 → pend_valid=1, pc holds.
  - Next stalled cycle br to 0x400 → pend_tgt=0x400.
  - stall=0 → pc=0x400, redirect=1, pend_valid=0.
- Misaligned target:
  - br_target=0x102 → pc=0x80, misalign and redirect pulse together.
- Wrap and reset mid-operation:
  - ADDR_W=8, STEP=4, pc=0xFC → next pc=0x00.
  - With pend_valid=1 and stall=1, assert rst_n=0 → pc=RESET_VEC, pend_valid=0, out_valid=0.
